// File: rtl/regfile_sb.sv
// Integer register file with write-to-read bypass, per-register pending scoreboard
// and a one-entry-per-cycle clear engine that runs after reset or on request.
module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clear_req,
  output logic            busy,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            pend1,
  output logic            pend2,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wd
);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  state_e             state_q;
  logic               busy_q;
  logic [AW-1:0]      clr_idx_q;
  logic [NREGS-1:0]   pend_q, pend_d;
  logic [XLEN-1:0]    mem [NREGS];
  logic               wr_fire, iss_fire;
  logic               hit1, hit2;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_fire  = we && (state_q == StIdle) && addr_ok(wr_addr);
  assign iss_fire = iss_valid && (state_q == StIdle) && addr_ok(iss_addr);
  assign busy     = busy_q;

  // Issue is applied after the write so a same-edge new producer keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (state_q == StIdle) begin
      if (clear_req) begin
        pend_d = '0;
      end else begin
        if (wr_fire)  pend_d[wr_addr]  = 1'b0;
        if (iss_fire) pend_d[iss_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StClear;
      busy_q    <= 1'b1;
      clr_idx_q <= '0;
      pend_q    <= '0;
    end else begin
      pend_q <= pend_d;
      unique case (state_q)
        StClear: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == LastIdx) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            clr_idx_q <= '0;
          end
        end
        StIdle: begin
          if (clear_req) begin
            state_q   <= StClear;
            busy_q    <= 1'b1;
            clr_idx_q <= '0;
          end
        end
        default: begin
          state_q <= StClear;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset; the clear engine is the only way it reaches a known state.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem[clr_idx_q] <= '0;
    end else if (wr_fire) begin
      mem[wr_addr] <= wd;
    end
  end

  assign hit1 = (BYPASS != 0) && wr_fire && (wr_addr == rs1_addr);
  assign hit2 = (BYPASS != 0) && wr_fire && (wr_addr == rs2_addr);

  always_comb begin
    rd1   = '0;
    pend1 = 1'b0;
    if (!busy_q && addr_ok(rs1_addr)) begin
      if (hit1) begin
        rd1 = wd;
      end else begin
        rd1   = mem[rs1_addr];
        pend1 = pend_q[rs1_addr];
      end
    end
  end

  always_comb begin
    rd2   = '0;
    pend2 = 1'b0;
    if (!busy_q && addr_ok(rs2_addr)) begin
      if (hit2) begin
        rd2 = wd;
      end else begin
        rd2   = mem[rs2_addr];
        pend2 = pend_q[rs2_addr];
      end
    end
  end

endmodule
